wac_adc_capture: RTL and testbench
==================================

Name: wac_adc_capture

Overview:
- Serial front-end for the board's two 12-bit SPI ADCs (16-clock frame: 4 leading zeros then 12 data bits, MSB first).
- Runs a burst of nSamples conversions on the channel selected by modeAdc.
- Delivers each result as dataAdc plus a one-cycle readyAdc strobe to the communication/BRAM controller.
- Sits between the ADC pins and that controller, inside the control stage.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; range 1..255. SCLK frequency = clk/(2*CLK_DIV).
- QUIET_CYC, 4: clk cycles CS is held high between conversions; range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- nRst  in  1  asynchronous active-low reset
- ctrlEn  in  1  start strobe, one clk cycle, sampled only in IDLE
- abort  in  1  level; forces return to IDLE
- modeAdc  in  1  channel select, 0=ADC1, 1=ADC2; latched at start
- nSamples  in  12  conversions per burst; latched at start
- SDOADC1  in  1  ADC1 serial data
- SDOADC2  in  1  ADC2 serial data
- CSADC1  out  1  ADC1 chip select, active low
- CLKADC1  out  1  ADC1 SCLK
- CSADC2  out  1  ADC2 chip select, active low
- CLKADC2  out  1  ADC2 SCLK
- dataAdc  out  12  last conversion result
- readyAdc  out  1  one-cycle strobe, dataAdc valid
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle strobe at end of burst or abort

Behaviour:
- Reset (async, nRst=0): state IDLE. CS both 1, CLK both 1, dataAdc=0, readyAdc=0, busy=0, done=0. Counters and shift register cleared. All outputs are registered.
- States: IDLE, SETUP, SHIFT, QUIET, FIN.
- IDLE:
  - ctrlEn=1 and nSamples!=0: latch mode and count; go to SETUP next cycle; busy=1.
  - ctrlEn=1 and nSamples==0: go to FIN (done pulse, no CS activity).
- SETUP: selected CS=0, SCLK=1, for CLK_DIV cycles, then SHIFT.
- SHIFT: 16 SCLK periods.
  - Each period: CLK_DIV cycles low, then CLK_DIV cycles high.
  - Selected SDO is shifted into a 16-bit register on the clk edge where SCLK goes 0->1.
  - After the 16th high half:
    - CS returns to 1.
    - dataAdc = shift[11:0]; the 4 leading bits are discarded and not checked.
    - readyAdc=1 for that single cycle.
    - Sample counter decrements; go to QUIET.
- Unselected ADC: CS=1 and SCLK=1 at all times.
- QUIET: CS=1 for QUIET_CYC cycles. Then SETUP if remaining count != 0, else FIN.
- FIN: done=1 for one cycle, busy=0 in the same cycle, next state IDLE.
- Timing per conversion: CS low for CLK_DIV + 32*CLK_DIV cycles. Start-to-first-readyAdc = 1 + 33*CLK_DIV cycles.
- ctrlEn outside IDLE is ignored. modeAdc and nSamples changes during a burst have no effect.
- abort=1 in any non-IDLE state:
  - Next cycle: CS=1, SCLK=1, state FIN.
  - No readyAdc for the partial frame; dataAdc holds its previous value.
  - abort in IDLE has no effect.
- abort coincident with the final readyAdc cycle: readyAdc still issues, then FIN.
- nSamples=4095 is the maximum; the counter never wraps.

Test Plan:
- Reset: hold nRst=0 mid-SHIFT -> all outputs return immediately to CS=1, CLK=1, dataAdc=0, busy=0. After release, state is IDLE.
- Single sample, ADC1: CLK_DIV=2, nSamples=1, SDOADC1 model drives 0000_1010_1011_1100 -> CSADC1 low for 66 cycles, 16 CLKADC1 pulses, dataAdc=12'hABC, readyAdc pulse at start+67, done one cycle after QUIET ends. CSADC2 and CLKADC2 stay high.
- Burst, ADC2: modeAdc=1, nSamples=3, model returns 12'h001, 12'h800, 12'hFFF -> three readyAdc pulses 66+4 cycles apart with those values, then a single done pulse. ADC1 pins stay idle.
- Zero count: nSamples=0, ctrlEn pulse -> done the next cycle, no CS edge, no readyAdc.
- Abort: assert abort at the 8th SCLK rise of sample 2 of 3 -> CS high the next cycle, exactly 1 readyAdc total, done pulse, busy low. A new ctrlEn then starts a fresh burst.
- Ignored start: pulse ctrlEn again during SHIFT, and change modeAdc and nSamples mid-burst -> burst count, channel and timing are unchanged.

Source files
------------

// File: rtl/wac_adc_capture_if.sv
// rtl/wac_adc_capture_if.sv - controller/ADC-pin bundle for the dual SPI ADC capture block
interface wac_adc_capture_if;
  logic        ctrlEn;
  logic        abort;
  logic        modeAdc;
  logic [11:0] nSamples;
  logic        SDOADC1;
  logic        SDOADC2;
  logic        CSADC1;
  logic        CLKADC1;
  logic        CSADC2;
  logic        CLKADC2;
  logic [11:0] dataAdc;
  logic        readyAdc;
  logic        busy;
  logic        done;

  modport master (
    output ctrlEn, abort, modeAdc, nSamples, SDOADC1, SDOADC2,
    input  CSADC1, CLKADC1, CSADC2, CLKADC2, dataAdc, readyAdc, busy, done
  );

  modport slave (
    input  ctrlEn, abort, modeAdc, nSamples, SDOADC1, SDOADC2,
    output CSADC1, CLKADC1, CSADC2, CLKADC2, dataAdc, readyAdc, busy, done
  );
endinterface

// File: rtl/wac_adc_capture.sv
// rtl/wac_adc_capture.sv - burst capture of 16-clock SPI frames from one of two 12-bit ADCs
module wac_adc_capture #(
  parameter int CLK_DIV   = 2,
  parameter int QUIET_CYC = 4
) (
  input logic               clk,
  input logic               nRst,
  wac_adc_capture_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, QUIET, FIN} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);

  state_t      state_q;
  logic        mode_q;
  logic [11:0] smp_cnt_q;
  logic [7:0]  div_cnt_q;
  logic [4:0]  half_cnt_q;
  logic [11:0] shift_q;
  logic        cs1_q, cs2_q, sclk1_q, sclk2_q;
  logic [11:0] data_q;
  logic        ready_q, busy_q, done_q;

  logic sdo_sel;
  logic div_last;
  logic shift_done;
  logic abort_act;

  assign sdo_sel    = mode_q ? bus.SDOADC2 : bus.SDOADC1;
  assign div_last   = (div_cnt_q == DIV_LAST);
  assign shift_done = (state_q == SHIFT) && div_last && (half_cnt_q == 5'd31);
  // A frame finishing on this edge still delivers its result; abort then acts from QUIET.
  assign abort_act  = bus.abort && !shift_done &&
                      (state_q == SETUP || state_q == SHIFT || state_q == QUIET);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      smp_cnt_q  <= '0;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      shift_q    <= '0;
      cs1_q      <= 1'b1;
      cs2_q      <= 1'b1;
      sclk1_q    <= 1'b1;
      sclk2_q    <= 1'b1;
      data_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort_act) begin
        state_q <= FIN;
        cs1_q   <= 1'b1;
        cs2_q   <= 1'b1;
        sclk1_q <= 1'b1;
        sclk2_q <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.ctrlEn) begin
              if (bus.nSamples != 12'd0) begin
                state_q   <= SETUP;
                mode_q    <= bus.modeAdc;
                smp_cnt_q <= bus.nSamples;
                busy_q    <= 1'b1;
                cs1_q     <= bus.modeAdc;
                cs2_q     <= ~bus.modeAdc;
                div_cnt_q <= '0;
              end else begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end
            end
          end
          SETUP: begin
            if (div_last) begin
              state_q    <= SHIFT;
              div_cnt_q  <= '0;
              half_cnt_q <= '0;
              sclk1_q    <= mode_q;
              sclk2_q    <= ~mode_q;
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          SHIFT: begin
            if (shift_done) begin
              state_q   <= QUIET;
              div_cnt_q <= '0;
              cs1_q     <= 1'b1;
              cs2_q     <= 1'b1;
              sclk1_q   <= 1'b1;
              sclk2_q   <= 1'b1;
              data_q    <= shift_q;
              ready_q   <= 1'b1;
              smp_cnt_q <= smp_cnt_q - 12'd1;
            end else if (div_last) begin
              div_cnt_q  <= '0;
              half_cnt_q <= half_cnt_q + 5'd1;
              // Even halves end low, so this edge is the SCLK rise; leading zeros fall off the top.
              if (!half_cnt_q[0]) begin
                sclk1_q <= 1'b1;
                sclk2_q <= 1'b1;
                shift_q <= {shift_q[10:0], sdo_sel};
              end else begin
                sclk1_q <= mode_q;
                sclk2_q <= ~mode_q;
              end
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          QUIET: begin
            if (div_cnt_q == QUIET_LAST) begin
              div_cnt_q <= '0;
              if (smp_cnt_q != 12'd0) begin
                state_q <= SETUP;
                cs1_q   <= mode_q;
                cs2_q   <= ~mode_q;
              end else begin
                state_q <= FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          FIN:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.CSADC1   = cs1_q;
  assign bus.CSADC2   = cs2_q;
  assign bus.CLKADC1  = sclk1_q;
  assign bus.CLKADC2  = sclk2_q;
  assign bus.dataAdc  = data_q;
  assign bus.readyAdc = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_wac_adc_capture.sv
// tb/tb_wac_adc_capture.sv - directed bench with a timeline model of each burst
module tb_wac_adc_capture;
  localparam int D = 2;
  localparam int Q = 4;
  localparam int P = 33 * D + Q;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  wac_adc_capture_if bus ();

  wac_adc_capture #(.CLK_DIV(D), .QUIET_CYC(Q)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Current burst: start edge, count, channel, abort edge, leading nibble, ADC words.
  int          b_k     = -1;
  int          b_n     = 0;
  int          b_abort = -1;
  logic        b_mode  = 1'b0;
  logic [3:0]  b_lead  = 4'h0;
  logic [11:0] words [8];
  bit          chk_en  = 1'b0;

  int n_ready = 0, n_done = 0, n_cs1_low = 0, n_cs2_low = 0;
  int last_ready = -1, last_done = -1;
  logic [11:0] exp_data = 12'h000;

  task automatic model(input int e, output logic cs1, output logic sc1, output logic cs2,
                       output logic sc2, output logic rdy, output logic bsy, output logic dn,
                       output int j);
    int d, r;
    logic cs, sc;
    cs1 = 1; sc1 = 1; cs2 = 1; sc2 = 1; rdy = 0; bsy = 0; dn = 0; j = 0;
    if (b_k < 0 || e < b_k) return;
    d = b_k + b_n * P;
    if (b_abort >= 0 && b_abort < d) d = b_abort;
    if (e == d) begin
      dn = 1;
      return;
    end
    if (e > d) return;
    bsy = 1;
    j   = (e - b_k) / P;
    r   = (e - b_k) % P;
    cs  = (r < 33 * D) ? 1'b0 : 1'b1;
    sc  = (r >= D && r < 33 * D && ((r - D) / D) % 2 == 0) ? 1'b0 : 1'b1;
    rdy = (r == 33 * D);
    if (b_mode) begin cs2 = cs; sc2 = sc; end
    else        begin cs1 = cs; sc1 = sc; end
  endtask

  always @(negedge clk) begin : cmp
    logic ec1, es1, ec2, es2, er, eb, ed;
    int j;
    if (!nRst) exp_data = 12'h000;
    if (bus.readyAdc) begin n_ready++; last_ready = cyc; end
    if (bus.done)     begin n_done++;  last_done  = cyc; end
    if (!bus.CSADC1) n_cs1_low++;
    if (!bus.CSADC2) n_cs2_low++;
    if (chk_en) begin
      model(cyc, ec1, es1, ec2, es2, er, eb, ed, j);
      if (er) exp_data = words[j % 8];
      check("CSADC1",   int'(bus.CSADC1),   int'(ec1));
      check("CLKADC1",  int'(bus.CLKADC1),  int'(es1));
      check("CSADC2",   int'(bus.CSADC2),   int'(ec2));
      check("CLKADC2",  int'(bus.CLKADC2),  int'(es2));
      check("readyAdc", int'(bus.readyAdc), int'(er));
      check("busy",     int'(bus.busy),     int'(eb));
      check("done",     int'(bus.done),     int'(ed));
      check("dataAdc",  int'(bus.dataAdc),  int'(exp_data));
    end
  end

  // ADC models: each SCLK fall presents the next frame bit, MSB first.
  int f1 = 0, f2 = 0;

  function automatic logic sdo_bit(input int f);
    logic [15:0] fr;
    int idx;
    idx = (b_k < 0) ? 0 : ((cyc - b_k) / P) % 8;
    fr  = {b_lead, words[idx]};
    return (f < 16) ? fr[15 - f] : 1'b0;
  endfunction

  always @(negedge bus.CLKADC1 or posedge bus.CSADC1) begin
    if (bus.CSADC1) f1 = 0;
    else begin bus.SDOADC1 = sdo_bit(f1); f1++; end
  end

  always @(negedge bus.CLKADC2 or posedge bus.CSADC2) begin
    if (bus.CSADC2) f2 = 0;
    else begin bus.SDOADC2 = sdo_bit(f2); f2++; end
  end

  task automatic start(input logic mode, input int n, input logic [3:0] lead);
    @(negedge clk);
    b_mode = mode; b_n = n; b_lead = lead; b_abort = -1; b_k = cyc + 1;
    bus.ctrlEn = 1'b1; bus.modeAdc = mode; bus.nSamples = 12'(n);
    @(negedge clk);
    bus.ctrlEn = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    int guard = 0;
    while (cyc < target && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    check("wait_edge", cyc, target);
  endtask

  int r0, d0, c1, c2;

  task automatic snap();
    r0 = n_ready; d0 = n_done; c1 = n_cs1_low; c2 = n_cs2_low;
  endtask

  initial begin
    bus.ctrlEn = 1'b0; bus.abort = 1'b0; bus.modeAdc = 1'b0; bus.nSamples = 12'd0;
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs1",  int'(bus.CSADC1),   1);
    check("rst_clk1", int'(bus.CLKADC1),  1);
    check("rst_cs2",  int'(bus.CSADC2),   1);
    check("rst_clk2", int'(bus.CLKADC2),  1);
    check("rst_data", int'(bus.dataAdc),  0);
    check("rst_busy", int'(bus.busy),     0);
    check("rst_rdy",  int'(bus.readyAdc), 0);
    check("rst_done", int'(bus.done),     0);
    nRst = 1'b1;
    chk_en = 1'b1;

    // Single sample on ADC1
    words[0] = 12'hABC;
    snap();
    start(1'b0, 1, 4'h0);
    wait_edge(b_k + P + 3);
    check("t1_ready_edge", last_ready - b_k, 66);
    check("t1_done_edge",  last_done - b_k,  70);
    check("t1_data",       int'(bus.dataAdc), 12'hABC);
    check("t1_nready",     n_ready - r0, 1);
    check("t1_ndone",      n_done - d0,  1);
    check("t1_cs1_low",    n_cs1_low - c1, 66);
    check("t1_cs2_low",    n_cs2_low - c2, 0);

    // Three-sample burst on ADC2, non-zero leading nibble must be dropped
    words[0] = 12'h001; words[1] = 12'h800; words[2] = 12'hFFF;
    snap();
    start(1'b1, 3, 4'hF);
    wait_edge(b_k + 3 * P + 3);
    check("t2_nready",     n_ready - r0, 3);
    check("t2_ndone",      n_done - d0,  1);
    check("t2_last_ready", last_ready - b_k, 206);
    check("t2_data",       int'(bus.dataAdc), 12'hFFF);
    check("t2_cs1_low",    n_cs1_low - c1, 0);
    check("t2_cs2_low",    n_cs2_low - c2, 198);

    // Zero count
    snap();
    start(1'b0, 0, 4'h0);
    wait_edge(b_k + 5);
    check("t3_done_edge", last_done - b_k, 0);
    check("t3_ndone",     n_done - d0,  1);
    check("t3_nready",    n_ready - r0, 0);
    check("t3_cs_low",    (n_cs1_low - c1) + (n_cs2_low - c2), 0);

    // Start, mode and count changes during a burst are ignored
    words[0] = 12'h123; words[1] = 12'h456;
    snap();
    start(1'b0, 2, 4'h3);
    wait_edge(b_k + 20);
    bus.ctrlEn = 1'b1; bus.modeAdc = 1'b1; bus.nSamples = 12'd7;
    @(negedge clk);
    bus.ctrlEn = 1'b0;
    wait_edge(b_k + 2 * P + 3);
    check("t4_nready",    n_ready - r0, 2);
    check("t4_done_edge", last_done - b_k, 140);
    check("t4_data",      int'(bus.dataAdc), 12'h456);
    check("t4_cs2_low",   n_cs2_low - c2, 0);
    bus.modeAdc = 1'b0;

    // Abort at the 8th SCLK rise of sample 2 of 3
    words[0] = 12'h5A5; words[1] = 12'h3C3; words[2] = 12'h777;
    snap();
    start(1'b0, 3, 4'h0);
    wait_edge(b_k + P + 16 * D);
    b_abort = cyc + 1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("t5_cs1_after", int'(bus.CSADC1), 1);
    check("t5_busy",      int'(bus.busy),   0);
    check("t5_done",      int'(bus.done),   1);
    wait_edge(cyc + 5);
    check("t5_done_edge", last_done - b_k, 103);
    check("t5_nready",    n_ready - r0, 1);
    check("t5_ndone",     n_done - d0,  1);
    check("t5_data",      int'(bus.dataAdc), 12'h5A5);

    // Fresh burst after abort
    words[0] = 12'h9E1;
    snap();
    start(1'b1, 1, 4'h6);
    wait_edge(b_k + P + 3);
    check("t6_nready", n_ready - r0, 1);
    check("t6_data",   int'(bus.dataAdc), 12'h9E1);

    // Asynchronous reset mid-SHIFT
    words[0] = 12'h2D2; words[1] = 12'h4B4;
    start(1'b0, 2, 4'h0);
    wait_edge(b_k + 20);
    chk_en = 1'b0;
    #2 nRst = 1'b0;
    #1;
    check("t7_cs1",  int'(bus.CSADC1),   1);
    check("t7_clk1", int'(bus.CLKADC1),  1);
    check("t7_data", int'(bus.dataAdc),  0);
    check("t7_busy", int'(bus.busy),     0);
    check("t7_rdy",  int'(bus.readyAdc), 0);
    repeat (2) @(negedge clk);
    b_k = -1;
    nRst = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // Burst after reset
    words[0] = 12'h0F0;
    snap();
    start(1'b0, 1, 4'h0);
    wait_edge(b_k + P + 3);
    check("t8_nready", n_ready - r0, 1);
    check("t8_data",   int'(bus.dataAdc), 12'h0F0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
